// File: rtl/dwc_rsp0.sv
// Response-path width down-converter: one wide co-processor word is unpacked into
// narrow words, least-significant word first, with a one-entry pending buffer.
module dwc_rsp0 #(
    parameter int NARROW_DATA_WIDTH = 32,
    parameter int WIDE_DATA_WIDTH   = 128,
    parameter int RSP_WORD_NUMBER   = WIDE_DATA_WIDTH / NARROW_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dwc_rsp_valid,
    output logic                         dwc_rsp_ready,
    input  logic [WIDE_DATA_WIDTH-1:0]   dwc_rsp_rdata,
    output logic                         fifo_rsp_valid,
    input  logic                         fifo_rsp_ready,
    output logic [NARROW_DATA_WIDTH-1:0] fifo_rsp_rdata,
    output logic [1:0]                   state
);

    localparam int IDX_W = (RSP_WORD_NUMBER > 1) ? $clog2(RSP_WORD_NUMBER) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RSP_WORD_NUMBER - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SEND    = 2'b01,
        FULL    = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    state_e                     state_q, state_d;
    logic [WIDE_DATA_WIDTH-1:0] act_buf_q, act_buf_d;
    logic [WIDE_DATA_WIDTH-1:0] pend_buf_q, pend_buf_d;
    logic [IDX_W-1:0]           idx_q, idx_d;

    logic in_hs;
    logic out_hs;
    logic last;

    // Handshake decode uses only registered state, so ready never depends on an input.
    assign dwc_rsp_ready  = (state_q != FULL);
    assign fifo_rsp_valid = (state_q == SEND) || (state_q == FULL);
    assign fifo_rsp_rdata = act_buf_q[idx_q*NARROW_DATA_WIDTH +: NARROW_DATA_WIDTH];
    assign state          = state_q;

    assign in_hs  = dwc_rsp_valid && dwc_rsp_ready;
    assign out_hs = fifo_rsp_valid && fifo_rsp_ready;
    assign last   = out_hs && (idx_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        act_buf_d  = act_buf_q;
        pend_buf_d = pend_buf_q;
        idx_d      = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    act_buf_d = dwc_rsp_rdata;
                    idx_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (last) begin
                    idx_d = '0;
                    if (in_hs) begin
                        act_buf_d = dwc_rsp_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (out_hs) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    // Arrival while still unpacking parks the new word behind the active one.
                    if (in_hs) begin
                        pend_buf_d = dwc_rsp_rdata;
                        state_d    = FULL;
                    end
                end
            end
            FULL: begin
                if (last) begin
                    act_buf_d = pend_buf_q;
                    idx_d     = '0;
                    state_d   = SEND;
                end else if (out_hs) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            act_buf_q  <= '0;
            pend_buf_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            act_buf_q  <= act_buf_d;
            pend_buf_q <= pend_buf_d;
            idx_q      <= idx_d;
        end
    end

endmodule

// File: tb/tb_dwc_rsp0.sv
// Bench for dwc_rsp0: a 128->32 build and a 32->32 build, each checked every cycle
// against a queue model of outstanding narrow words.
module tb_dwc_rsp0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, rsp_valid, rsp_ready, fifo_valid, fifo_ready;
    logic [127:0] rsp_rdata;
    logic [31:0]  fifo_rdata;
    logic [1:0]   state;

    logic         rst1_n, v1, r1, fv1, fr1;
    logic [31:0]  d1, fd1;
    logic [1:0]   st1;

    dwc_rsp0 #(.NARROW_DATA_WIDTH(32), .WIDE_DATA_WIDTH(128)) dut (
        .clk(clk), .rst_n(rst_n),
        .dwc_rsp_valid(rsp_valid), .dwc_rsp_ready(rsp_ready), .dwc_rsp_rdata(rsp_rdata),
        .fifo_rsp_valid(fifo_valid), .fifo_rsp_ready(fifo_ready), .fifo_rsp_rdata(fifo_rdata),
        .state(state)
    );

    dwc_rsp0 #(.NARROW_DATA_WIDTH(32), .WIDE_DATA_WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rst1_n),
        .dwc_rsp_valid(v1), .dwc_rsp_ready(r1), .dwc_rsp_rdata(d1),
        .fifo_rsp_valid(fv1), .fifo_rsp_ready(fr1), .fifo_rsp_rdata(fd1),
        .state(st1)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: queue of narrow words still owed to the processor side.
    logic [31:0] exp_q[$];
    logic [31:0] exp1_q[$];
    logic [35:0] s_vec, e_vec;     // {valid, ready, state, rdata}
    logic [35:0] s1_vec, e1_vec;

    function automatic logic [127:0] rand_wide();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle: sample outputs, predict them from the model, drive inputs, advance model.
    task automatic tick(input logic v, input logic [127:0] d, input logic r);
        int wides;
        logic e_v, e_r;
        @(negedge clk);
        wides = (exp_q.size() + 3) / 4;
        e_v   = (wides > 0);
        e_r   = (wides < 2);
        e_vec = {e_v, e_r, 2'(wides), e_v ? exp_q[0] : 32'h0};
        s_vec = {fifo_valid, rsp_ready, state, e_v ? fifo_rdata : 32'h0};
        rsp_valid  = v;
        rsp_rdata  = d;
        fifo_ready = r;
        if (e_v && r) void'(exp_q.pop_front());
        if (v && e_r) for (int i = 0; i < 4; i++) exp_q.push_back(d[i*32 +: 32]);
    endtask

    task automatic tick1(input logic v, input logic [31:0] d, input logic r,
                         output logic acc, output logic del);
        int wides;
        logic e_v, e_r;
        @(negedge clk);
        wides  = exp1_q.size();
        e_v    = (wides > 0);
        e_r    = (wides < 2);
        e1_vec = {e_v, e_r, 2'(wides), e_v ? exp1_q[0] : 32'h0};
        s1_vec = {fv1, r1, st1, e_v ? fd1 : 32'h0};
        v1  = v;
        d1  = d;
        fr1 = r;
        del = e_v && r;
        acc = v && e_r;
        if (del) void'(exp1_q.pop_front());
        if (acc) exp1_q.push_back(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0;
        rsp_valid = 1'b0; rsp_rdata = '0; fifo_ready = 1'b0;
        v1 = 1'b0; d1 = '0; fr1 = 1'b0;
        #12;
        n_chk++;
        if ({fifo_valid, rsp_ready, state, fifo_rdata} !== {1'b0, 1'b1, 2'b00, 32'h0})
            $display("FAIL reset_state: got %h expected %h",
                     {fifo_valid, rsp_ready, state, fifo_rdata}, {1'b0, 1'b1, 2'b00, 32'h0});
        else n_pass++;
        n_chk++;
        if ({fv1, r1, st1} !== 4'b0100)
            $display("FAIL reset_state_n1: got %b expected 0100", {fv1, r1, st1});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; rst1_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] w[4];
        w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        tick(1'b1, 128'h44444444_33333333_22222222_11111111, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, '0, 1'b1);
            n_chk++;
            if (s_vec[35] !== 1'b1 || s_vec[31:0] !== w[k])
                $display("FAIL single_word%0d: got v=%b d=%h expected v=1 d=%h",
                         k, s_vec[35], s_vec[31:0], w[k]);
            else n_pass++;
        end
        tick(1'b0, '0, 1'b1);
        n_chk++;
        if ({s_vec[35], s_vec[33:32]} !== 3'b000)
            $display("FAIL single_end: got v=%b st=%b expected v=0 st=00", s_vec[35], s_vec[33:32]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [255:0] ab;
        logic saw_full;
        ab = {rand_wide(), rand_wide()};
        saw_full = 1'b0;
        tick(1'b1, ab[127:0], 1'b1);
        tick(1'b1, ab[255:128], 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick(1'b0, '0, 1'b1);
            if (s_vec[33:32] === 2'b10) saw_full = 1'b1;
            n_chk++;
            if (s_vec !== e_vec || s_vec[35] !== 1'b1 || s_vec[31:0] !== ab[k*32 +: 32])
                $display("FAIL b2b_word%0d: got %h expected %h (word %h)",
                         k, s_vec, e_vec, ab[k*32 +: 32]);
            else n_pass++;
        end
        n_chk++;
        if (saw_full !== 1'b1) $display("FAIL b2b_full_state: got %b expected 1", saw_full);
        else n_pass++;
        tick(1'b0, '0, 1'b1);
        n_chk++;
        if (s_vec !== e_vec || s_vec[35] !== 1'b0)
            $display("FAIL b2b_end: got %h expected %h", s_vec, e_vec);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [255:0] ab;
        ab = {rand_wide(), rand_wide()};
        tick(1'b1, ab[127:0], 1'b0);
        tick(1'b1, ab[255:128], 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, rand_wide(), 1'b0);
            n_chk++;
            if ({s_vec[35:34], s_vec[31:0]} !== {2'b10, ab[31:0]} || s_vec !== e_vec)
                $display("FAIL bp_hold%0d: got %h expected %h", k, s_vec, {2'b10, 2'b10, ab[31:0]});
            else n_pass++;
        end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, '0, 1'b1);
            n_chk++;
            if (s_vec !== e_vec || s_vec[31:0] !== ab[k*32 +: 32])
                $display("FAIL bp_drain%0d: got %h expected %h", k, s_vec, e_vec);
            else n_pass++;
        end
        tick(1'b0, '0, 1'b1);
    endtask

    task automatic test_last_and_new();
        logic [127:0] a, b;
        a = rand_wide();
        b = rand_wide();
        tick(1'b1, a, 1'b1);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        tick(1'b1, b, 1'b1);
        n_chk++;
        if (s_vec[31:0] !== a[127:96] || s_vec[33:32] !== 2'b01)
            $display("FAIL lastnew_a3: got %h expected st=01 d=%h", s_vec, a[127:96]);
        else n_pass++;
        tick(1'b0, '0, 1'b1);
        n_chk++;
        if ({s_vec[35], s_vec[33:32], s_vec[31:0]} !== {3'b101, b[31:0]})
            $display("FAIL lastnew_b0: got %h expected v=1 st=01 d=%h", s_vec, b[31:0]);
        else n_pass++;
        for (int k = 0; k < 4; k++) tick(1'b0, '0, 1'b1);
        n_chk++;
        if (s_vec !== e_vec) $display("FAIL lastnew_end: got %h expected %h", s_vec, e_vec);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int k = 0; k < 300; k++) begin
            tick(($urandom % 3) != 0, rand_wide(), ($urandom % 4) != 0);
            n_chk++;
            if (s_vec !== e_vec) begin
                errs++;
                if (errs < 10) $display("FAIL random_cyc%0d: got %h expected %h", k, s_vec, e_vec);
            end else n_pass++;
        end
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, '0, 1'b1);
            n_chk++;
            if (s_vec !== e_vec) $display("FAIL random_drain%0d: got %h expected %h", k, s_vec, e_vec);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, rand_wide(), 1'b1);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_chk++;
        if ({fifo_valid, rsp_ready, state} !== 4'b0100)
            $display("FAIL reset_mid: got %b expected 0100", {fifo_valid, rsp_ready, state});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, '0, 1'b1);
            n_chk++;
            if (s_vec !== e_vec || s_vec[35] !== 1'b0)
                $display("FAIL reset_mid_after%0d: got %h expected %h", k, s_vec, e_vec);
            else n_pass++;
        end
    endtask

    task automatic test_n1();
        logic [31:0] w[3];
        logic [31:0] got[$];
        logic acc, del;
        int sent;
        sent = 0;
        for (int k = 0; k < 3; k++) w[k] = $urandom;
        for (int k = 0; k < 40; k++) begin
            tick1(sent < 3, (sent < 3) ? w[sent] : 32'h0, (k >= 30) || ($urandom % 2 == 1), acc, del);
            if (del) got.push_back(s1_vec[31:0]);
            if (acc) sent++;
            n_chk++;
            if (s1_vec !== e1_vec) $display("FAIL n1_cyc%0d: got %h expected %h", k, s1_vec, e1_vec);
            else n_pass++;
        end
        n_chk++;
        if (got.size() != 3) $display("FAIL n1_count: got %0d expected 3", got.size());
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (k >= got.size() || got[k] !== w[k])
                $display("FAIL n1_word%0d: got %h expected %h", k, (k < got.size()) ? got[k] : 32'hx, w[k]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_last_and_new();
        test_random();
        test_reset_mid();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dwc_rsp0.md
Name: dwc_rsp0

Overview:
Width down-converter for the response path, the counterpart of the command up-converter. It accepts one wide response word from the co-processor and unpacks it into narrow words for the processor-side response FIFO, least-significant word first, which mirrors the command packing order. A one-entry pending buffer sustains full narrow-side throughput across back-to-back wide responses.

Parameters:
NARROW_DATA_WIDTH, 32, processor-side word width.
WIDE_DATA_WIDTH, 128, co-processor-side word width; must be an integer multiple of NARROW_DATA_WIDTH.
RSP_WORD_NUMBER, WIDE_DATA_WIDTH/NARROW_DATA_WIDTH, narrow words per wide word; must be >= 1.

Ports:
clk  input  1  single clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
dwc_rsp_valid  input  1  co-processor response valid.
dwc_rsp_ready  output  1  converter can accept a wide word.
dwc_rsp_rdata  input  WIDE_DATA_WIDTH  wide response data.
fifo_rsp_valid  output  1  narrow word available to processor side.
fifo_rsp_ready  input  1  processor side accepts the narrow word.
fifo_rsp_rdata  output  NARROW_DATA_WIDTH  narrow response data.
state  output  2  current state encoding, for debug.

Behaviour:
- Storage: active buffer act_buf (wide), pending buffer pend_buf (wide), word index idx (width max(1,$clog2(RSP_WORD_NUMBER))).
- States: IDLE=2'b00 (no data), SEND=2'b01 (act valid, pend empty), FULL=2'b10 (act and pend valid). 2'b11 is illegal and returns to IDLE. The state port is driven directly by the state register.
- dwc_rsp_ready = (state != FULL). It is decoded from the state register only, with no combinational path from any input.
- fifo_rsp_valid = (state == SEND or FULL).
- fifo_rsp_rdata = act_buf[idx*NARROW_DATA_WIDTH +: NARROW_DATA_WIDTH]. It is driven from registers.
- in_hs = dwc_rsp_valid && dwc_rsp_ready. out_hs = fifo_rsp_valid && fifo_rsp_ready. last = out_hs && idx == RSP_WORD_NUMBER-1.
- IDLE:
  - in_hs: act_buf <= dwc_rsp_rdata, idx <= 0, go to SEND.
- SEND:
  - out_hs and not last: idx <= idx+1.
  - last and in_hs: act_buf <= dwc_rsp_rdata, idx <= 0, stay in SEND.
  - last and no in_hs: idx <= 0, go to IDLE.
  - in_hs and not last: pend_buf <= dwc_rsp_rdata, go to FULL. Any out_hs idx increment in the same cycle still applies.
- FULL (input is stalled):
  - out_hs and not last: idx <= idx+1.
  - last: act_buf <= pend_buf, idx <= 0, go to SEND.
- Latency: a wide word accepted at edge t presents narrow word 0 from cycle t+1.
- Throughput: with fifo_rsp_ready held high and dwc_rsp_valid held high, fifo_rsp_valid stays continuously high. That gives one narrow word per cycle with no bubble between wide words.
- RSP_WORD_NUMBER==1: every out_hs is last, idx stays 0, and the block acts as a 2-deep pass-through.
- Holding rules:
  - fifo_rsp_rdata and fifo_rsp_valid stay stable while fifo_rsp_valid && !fifo_rsp_ready.
  - Input data is sampled only on in_hs.
- Reset values: state=IDLE, dwc_rsp_ready=1 (decoded from IDLE), fifo_rsp_valid=0, fifo_rsp_rdata=0, state port=2'b00. act_buf, pend_buf and idx are all cleared to 0.
- Reset mid-operation discards all buffered words. No partial word is emitted after reset is released.

Test Plan:
- Single response: reset, then drive dwc_rsp_rdata=128'h44444444_33333333_22222222_11111111 for one in_hs, with fifo_rsp_ready=1. Required: fifo_rsp_rdata = 11111111, 22222222, 33333333, 44444444 on 4 consecutive cycles starting 1 cycle after in_hs, then fifo_rsp_valid=0 and state=00.
- Back-to-back: hold dwc_rsp_valid=1 with two wide words A and B, and fifo_rsp_ready=1. Required: 8 consecutive narrow words A0..A3 then B0..B3 with no gap, and state passes through 10 while B waits.
- Output backpressure: fill act and pend, then hold fifo_rsp_ready=0 for 5 cycles. Required: dwc_rsp_ready=0, and fifo_rsp_valid and fifo_rsp_rdata are stable at word 0. After release, all 8 words arrive in order.
- Simultaneous last pop and new input in SEND: at idx=3, apply fifo_rsp_ready=1 and dwc_rsp_valid=1 together. Required: state stays 01, and the next cycle shows word 0 of the new response.
- Reset mid-burst: assert rst_n=0 after 2 of 4 words. Required: outputs immediately show fifo_rsp_valid=0, dwc_rsp_ready=1 and state=00. No leftover words appear after release.
- RSP_WORD_NUMBER=1 build (both widths 32): stream 3 words with random fifo_rsp_ready. Required: all 3 are delivered in order, unmodified, and none are lost or duplicated.
